// File: rtl/serial_frame_router_if.sv
// Bus bundle for serial_frame_router: button/data in, per-channel routed bits,
// display and status out.
interface serial_frame_router_if #(
  parameter int NUM_CH = 4
) ();
  logic              push_button;
  logic              serIn;
  logic [NUM_CH-1:0] serOut;
  logic [NUM_CH-1:0] serOutValid;
  logic [6:0]        seg_out;
  logic              busy;
  logic              frame_done;
  logic              addr_err;

  modport master (
    output push_button, serIn,
    input  serOut, serOutValid, seg_out, busy, frame_done, addr_err
  );

  modport slave (
    input  push_button, serIn,
    output serOut, serOutValid, seg_out, busy, frame_done, addr_err
  );
endinterface

// File: rtl/serial_frame_router.sv
// Button-strobed serial frame receiver: start bit, address, length, payload;
// payload bits are forwarded to the addressed output channel.

module sfr_lane (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  input  logic din,
  input  logic clr,
  output logic so,
  output logic sov
);
  always_ff @(posedge clk) begin
    if (rst) begin
      so  <= 1'b0;
      sov <= 1'b0;
    end else begin
      sov <= fire;
      if (clr)       so <= 1'b0;
      else if (fire) so <= din;
    end
  end
endmodule

module serial_frame_router #(
  parameter int NUM_CH         = 4,
  parameter int LEN_W          = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_frame_router_if.slave  bus
);
  localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_t;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  // Synchroniser and edge history reset high: a button held through reset
  // must be released before it can strobe again.
  logic s1, s2, s3, smp;
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3} <= 3'b111;
    else     {s1, s2, s3} <= {bus.push_button, s1, s2};
  end
  assign smp = s2 & ~s3;

  state_t            state;
  logic [3:0]        bcnt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LEN_W-1:0]  cnt, len_nxt;
  logic [3:0]        cnt4;
  logic              drop, busy_q, fd_q, ae_q;
  logic [6:0]        seg_q;

  assign addr_nxt = ADDR_W'({addr_q, bus.serIn});
  assign len_nxt  = LEN_W'({cnt, bus.serIn});
  assign cnt4     = 4'(cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bcnt   <= '0;
      addr_q <= '0;
      cnt    <= '0;
      drop   <= 1'b0;
      busy_q <= 1'b0;
      fd_q   <= 1'b0;
      ae_q   <= 1'b0;
      seg_q  <= hex7(4'h0);
    end else begin
      fd_q  <= 1'b0;
      ae_q  <= 1'b0;
      seg_q <= hex7((state == DATA) ? cnt4 : 4'h0);
      case (state)
        IDLE: if (smp && !bus.serIn) begin
          state  <= ADDR;
          bcnt   <= '0;
          addr_q <= '0;
          drop   <= 1'b0;
          busy_q <= 1'b1;
        end
        ADDR: if (smp) begin
          addr_q <= addr_nxt;
          bcnt   <= bcnt + 4'd1;
          if (bcnt == 4'(ADDR_W - 1)) begin
            state <= LEN;
            bcnt  <= '0;
            cnt   <= '0;
            drop  <= (32'(addr_nxt) >= NUM_CH);
          end
        end
        LEN: if (smp) begin
          cnt  <= len_nxt;
          bcnt <= bcnt + 4'd1;
          if (bcnt == 4'(LEN_W - 1)) begin
            bcnt <= '0;
            if (len_nxt == '0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              fd_q   <= 1'b1;
              ae_q   <= drop;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: if (smp) begin
          cnt <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            fd_q   <= 1'b1;
            ae_q   <= drop;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_CH-1:0] fire, so_w, sov_w;
  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CH; i++)
      fire[i] = (state == DATA) && smp && !drop && (32'(addr_q) == i);
  end

  // Lane data clears the cycle after frame_done, i.e. right after the last valid.
  sfr_lane u_lane [NUM_CH-1:0] (
    .clk  (clk),
    .rst  (rst),
    .fire (fire),
    .din  (bus.serIn),
    .clr  (fd_q),
    .so   (so_w),
    .sov  (sov_w)
  );

  assign bus.serOut      = so_w;
  assign bus.serOutValid = sov_w;
  assign bus.seg_out     = seg_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = fd_q;
  assign bus.addr_err    = ae_q;
endmodule
